// File: rtl/heavy_part_table_compare3.sv
// Bucket-3 heavy-part compare/update stage: pairs a record with its RAM3 bucket, applies the
// Elastic vote/evict rule, writes the bucket back and queues mismatching flows for the light part.
module heavy_part_table_compare3 #(
  parameter int RD_LAT       = 2,
  parameter int LAMBDA_SHIFT = 3,
  parameter int EV_DEPTH     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ip_addr_in_wr,
  input  logic [127:0] ip_addr_in,
  output logic         ip_addr_in_alf,
  input  logic [95:0]  ram_q_in,
  output logic         ram_wren,
  output logic [11:0]  ram_wraddr,
  output logic [95:0]  ram_wrdata,
  output logic         light_out_wr,
  output logic [63:0]  light_out,
  input  logic         light_out_alf,
  output logic [31:0]  drop_cnt
);

  // state  | meaning
  // INIT_S | zero-fill sweep of all 4096 buckets, inputs ignored
  // RUN_S  | per-record bucket compare and write-back
  typedef enum logic {INIT_S = 1'b0, RUN_S = 1'b1} state_t;

  localparam int AW   = $clog2(EV_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CMPW = 33 + LAMBDA_SHIFT;

  state_t       state, state_nxt;
  logic [11:0]  init_addr;

  logic [RD_LAT-1:0] rec_vld;
  logic [31:0]       rec_ip  [RD_LAT];
  logic [31:0]       rec_val [RD_LAT];

  logic [RD_LAT-1:0] hist_vld;
  logic [11:0]       hist_addr [RD_LAT];
  logic [95:0]       hist_data [RD_LAT];

  logic [31:0] cur_ip, cur_val;
  logic [11:0] cur_addr;
  logic [95:0] bucket;
  logic [31:0] b_key, b_pos;
  logic        b_flag;
  logic [30:0] b_neg;
  logic [32:0] sum_pos, sum_neg;
  logic [31:0] pos_sat;
  logic [30:0] neg_sat;
  logic        evict;

  logic        wr_en_d, push_d;
  logic [11:0] wr_addr_d;
  logic [95:0] wr_data_d;
  logic [63:0] push_rec_d;
  logic        push_vld;
  logic [63:0] push_rec;

  logic [63:0]   fifo_mem [EV_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty, pop, push_ok;

  logic unused_bits;
  assign unused_bits = ^ip_addr_in[127:64];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT_S;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT_S && init_addr == 12'hFFF) state_nxt = RUN_S;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                init_addr <= '0;
    else if (state == INIT_S)  init_addr <= init_addr + 12'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        rec_ip[i]  <= '0;
        rec_val[i] <= '0;
      end
    end else begin
      rec_vld[0] <= ip_addr_in_wr && (state == RUN_S);
      rec_ip[0]  <= ip_addr_in[63:32];
      rec_val[0] <= ip_addr_in[31:0];
      for (int i = 1; i < RD_LAT; i++) begin
        rec_vld[i] <= rec_vld[i-1];
        rec_ip[i]  <= rec_ip[i-1];
        rec_val[i] <= rec_val[i-1];
      end
    end
  end

  assign cur_ip   = rec_ip[RD_LAT-1];
  assign cur_val  = rec_val[RD_LAT-1];
  assign cur_addr = cur_ip[23:12];

  // Writes issued after the read was launched are invisible in ram_q_in; newest matching write wins.
  always_comb begin
    bucket = ram_q_in;
    for (int i = RD_LAT - 1; i >= 0; i--) begin
      if (hist_vld[i] && hist_addr[i] == cur_addr) bucket = hist_data[i];
    end
    if (ram_wren && ram_wraddr == cur_addr) bucket = ram_wrdata;
  end

  assign b_key   = bucket[95:64];
  assign b_pos   = bucket[63:32];
  assign b_flag  = bucket[31];
  assign b_neg   = bucket[30:0];
  assign sum_pos = {1'b0, b_pos} + {1'b0, cur_val};
  assign sum_neg = {2'b00, b_neg} + {1'b0, cur_val};
  assign pos_sat = sum_pos[32] ? '1 : sum_pos[31:0];
  assign neg_sat = (sum_neg[32:31] != 2'b00) ? '1 : sum_neg[30:0];
  assign evict   = CMPW'(neg_sat) >= (CMPW'(b_pos) << LAMBDA_SHIFT);

  always_comb begin
    wr_en_d    = 1'b0;
    wr_addr_d  = cur_addr;
    wr_data_d  = bucket;
    push_d     = 1'b0;
    push_rec_d = {b_key, b_pos};
    if (state == INIT_S) begin
      wr_en_d   = 1'b1;
      wr_addr_d = init_addr;
      wr_data_d = '0;
    end else if (rec_vld[RD_LAT-1]) begin
      wr_en_d = 1'b1;
      if (b_pos == '0) begin
        wr_data_d = {cur_ip, cur_val, 1'b0, 31'd0};
      end else if (b_key == cur_ip) begin
        wr_data_d = {b_key, pos_sat, b_flag, b_neg};
      end else if (evict) begin
        wr_data_d  = {cur_ip, cur_val, 1'b1, 31'd0};
        push_d     = 1'b1;
        push_rec_d = {b_key, b_pos};
      end else begin
        wr_data_d  = {b_key, b_pos, b_flag, neg_sat};
        push_d     = 1'b1;
        push_rec_d = {cur_ip, cur_val};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_wren   <= 1'b0;
      ram_wraddr <= '0;
      ram_wrdata <= '0;
      push_vld   <= 1'b0;
      push_rec   <= '0;
      hist_vld   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        hist_addr[i] <= '0;
        hist_data[i] <= '0;
      end
    end else begin
      ram_wren     <= wr_en_d;
      ram_wraddr   <= wr_addr_d;
      ram_wrdata   <= wr_data_d;
      push_vld     <= push_d;
      push_rec     <= push_rec_d;
      hist_vld[0]  <= ram_wren;
      hist_addr[0] <= ram_wraddr;
      hist_data[0] <= ram_wrdata;
      for (int i = 1; i < RD_LAT; i++) begin
        hist_vld[i]  <= hist_vld[i-1];
        hist_addr[i] <= hist_addr[i-1];
        hist_data[i] <= hist_data[i-1];
      end
    end
  end

  assign fifo_full  = (fifo_cnt == CW'(EV_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = !fifo_empty && !light_out_alf;
  assign push_ok    = push_vld && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_rec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
      light_out_wr   <= 1'b0;
      light_out      <= '0;
      drop_cnt       <= '0;
      ip_addr_in_alf <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        light_out <= fifo_mem[rd_ptr];
      end
      light_out_wr <= pop;
      if (push_ok && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push_ok && pop) fifo_cnt <= fifo_cnt - 1'b1;
      if (push_vld && !push_ok && drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
      ip_addr_in_alf <= (state != RUN_S) || ((EV_DEPTH - int'(fifo_cnt)) <= RD_LAT + 4);
    end
  end

endmodule

// File: tb/tb_heavy_part_table_compare3.sv
// Bench for heavy_part_table_compare3: spec vector table, randomized traffic against a
// sequential bucket model, and init/overflow/reset corner sequences.
module tb_heavy_part_table_compare3;
  localparam int RD_LAT = 2;
  localparam int LS     = 3;
  localparam int DEPTH  = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ip_addr_in_wr = 1'b0;
  logic [127:0] ip_addr_in = '0;
  logic         ip_addr_in_alf;
  logic [95:0]  ram_q_in;
  logic         ram_wren;
  logic [11:0]  ram_wraddr;
  logic [95:0]  ram_wrdata;
  logic         light_out_wr;
  logic [63:0]  light_out;
  logic         light_out_alf = 1'b0;
  logic [31:0]  drop_cnt;

  always #5 clk = ~clk;

  heavy_part_table_compare3 #(.RD_LAT(RD_LAT), .LAMBDA_SHIFT(LS), .EV_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ip_addr_in_wr(ip_addr_in_wr), .ip_addr_in(ip_addr_in),
    .ip_addr_in_alf(ip_addr_in_alf), .ram_q_in(ram_q_in), .ram_wren(ram_wren),
    .ram_wraddr(ram_wraddr), .ram_wrdata(ram_wrdata), .light_out_wr(light_out_wr),
    .light_out(light_out), .light_out_alf(light_out_alf), .drop_cnt(drop_cnt)
  );

  // RAM3 with RD_LAT read latency; a read sees only writes from earlier cycles.
  logic [95:0] ram [4096];
  logic [95:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (ram_wren) ram[ram_wraddr] <= ram_wrdata;
    rd_pipe[0] <= ram[ip_addr_in[55:44]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_q_in = rd_pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int cyc; logic [11:0] addr; logic [95:0] data; } wexp_t;
  wexp_t       wq [$];
  logic [63:0] lq [$];
  bit          mon_en = 1'b0;
  logic [95:0] model_mem [4096];

  typedef struct {
    logic [31:0] ip; logic [31:0] val; int gap;
    logic [11:0] addr; logic [95:0] wd; bit lv; logic [63:0] lrec;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Buckets applied strictly in arrival order; the DUT's bypass must make it look like this.
  function automatic void model_apply(input logic [31:0] ip, input logic [31:0] v,
                                      output logic [95:0] wd, output bit lv, output logic [63:0] lr);
    logic [95:0] b;
    logic [31:0] k, p;
    logic        f;
    logic [30:0] n;
    longint      s;
    b = model_mem[ip[23:12]];
    k = b[95:64]; p = b[63:32]; f = b[31]; n = b[30:0];
    lv = 1'b0;
    lr = '0;
    if (p == 0) begin
      wd = {ip, v, 1'b0, 31'd0};
    end else if (k == ip) begin
      s = longint'({32'd0, p}) + longint'({32'd0, v});
      if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
      wd = {k, s[31:0], f, n};
    end else begin
      s = longint'({33'd0, n}) + longint'({32'd0, v});
      if (s > 64'h7FFF_FFFF) s = 64'h7FFF_FFFF;
      lv = 1'b1;
      if (s >= longint'({32'd0, p}) * (64'd1 << LS)) begin
        wd = {ip, v, 1'b1, 31'd0};
        lr = {k, p};
      end else begin
        wd = {k, p, f, s[30:0]};
        lr = {ip, v};
      end
    end
    model_mem[ip[23:12]] = wd;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (ram_wren) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 96'(ram_wraddr), 96'hFFF_FFFF);
        end else begin
          wexp_t e;
          e = wq.pop_front();
          chk("write_addr", 96'(ram_wraddr), 96'(e.addr));
          chk("write_data", ram_wrdata, e.data);
          chk("write_cycle", 96'(cyc), 96'(e.cyc));
        end
      end
      if (light_out_wr) begin
        if (lq.size() == 0) chk("unexpected_light", 96'(light_out), 96'hF_FFFF_FFFF_FFFF_FFFF);
        else                chk("light_out", 96'(light_out), 96'(lq.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    ip_addr_in_wr = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] ip, input logic [31:0] v, input bit use_tab, input vec_t tv);
    logic [95:0] wd;
    bit          lv;
    logic [63:0] lr;
    wexp_t       e;
    model_apply(ip, v, wd, lv, lr);
    if (use_tab) begin
      wd = tv.wd; lv = tv.lv; lr = tv.lrec;
    end
    e.cyc  = cyc + RD_LAT + 1;
    e.addr = use_tab ? tv.addr : ip[23:12];
    e.data = wd;
    wq.push_back(e);
    if (lv) lq.push_back(lr);
    ip_addr_in_wr = 1'b1;
    ip_addr_in    = {$urandom(), $urandom(), ip, v};
    @(negedge clk);
    ip_addr_in_wr = 1'b0;
  endtask

  task automatic drain(input int lim);
    int t = 0;
    while ((wq.size() != 0 || lq.size() != 0) && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk("drain_writes", 96'(wq.size()), 96'd0);
    chk("drain_lights", 96'(lq.size()), 96'd0);
  endtask

  task automatic init_sweep();
    int n = 0, bad = 0, lbad = 0, t = 0;
    while (ip_addr_in_alf && t < 5000) begin
      @(negedge clk);
      t++;
      if (ram_wren) begin
        if (ram_wraddr !== n[11:0] || ram_wrdata !== 96'd0) bad++;
        n++;
      end
      if (light_out_wr) lbad++;
    end
    chk("init_write_count", 96'(n), 96'd4096);
    chk("init_write_bad", 96'(bad), 96'd0);
    chk("init_light_out", 96'(lbad), 96'd0);
    chk("init_alf_drop", 96'(ip_addr_in_alf), 96'd0);
    for (int i = 0; i < 4096; i++) model_mem[i] = '0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_ram_wren", 96'(ram_wren), 96'd0);
    chk("rst_ram_wraddr", 96'(ram_wraddr), 96'd0);
    chk("rst_ram_wrdata", ram_wrdata, 96'd0);
    chk("rst_light_wr", 96'(light_out_wr), 96'd0);
    chk("rst_light_out", 96'(light_out), 96'd0);
    chk("rst_drop_cnt", 96'(drop_cnt), 96'd0);
    chk("rst_alf", 96'(ip_addr_in_alf), 96'd1);
  endtask

  initial begin
    vec_t none;
    none = '{32'd0, 32'd0, 0, 12'd0, 96'd0, 1'b0, 64'd0};
    vecs[0]  = '{32'h0A000123, 32'd5, 5, 12'h000, {32'h0A000123, 32'd5, 1'b0, 31'd0}, 1'b0, 64'd0};
    vecs[1]  = '{32'h0A000123, 32'd5, 0, 12'h000, {32'h0A000123, 32'd10, 1'b0, 31'd0}, 1'b0, 64'd0};
    vecs[2]  = '{32'h0A000123, 32'd5, 5, 12'h000, {32'h0A000123, 32'd15, 1'b0, 31'd0}, 1'b0, 64'd0};
    vecs[3]  = '{32'h0B001001, 32'd4, 5, 12'h001, {32'h0B001001, 32'd4, 1'b0, 31'd0}, 1'b0, 64'd0};
    vecs[4]  = '{32'h0C001002, 32'd1, 5, 12'h001, {32'h0B001001, 32'd4, 1'b0, 31'd1}, 1'b1, {32'h0C001002, 32'd1}};
    vecs[5]  = '{32'h0D002001, 32'd1, 0, 12'h002, {32'h0D002001, 32'd1, 1'b0, 31'd0}, 1'b0, 64'd0};
    vecs[6]  = '{32'h0E002777, 32'd7, 0, 12'h002, {32'h0D002001, 32'd1, 1'b0, 31'd7}, 1'b1, {32'h0E002777, 32'd7}};
    vecs[7]  = '{32'h0E002777, 32'd1, 5, 12'h002, {32'h0E002777, 32'd1, 1'b1, 31'd0}, 1'b1, {32'h0D002001, 32'd1}};
    vecs[8]  = '{32'h0F003000, 32'hFFFFFFF0, 0, 12'h003, {32'h0F003000, 32'hFFFFFFF0, 1'b0, 31'd0}, 1'b0, 64'd0};
    vecs[9]  = '{32'h0F003000, 32'h00000100, 0, 12'h003, {32'h0F003000, 32'hFFFFFFFF, 1'b0, 31'd0}, 1'b0, 64'd0};
    vecs[10] = '{32'h1F003ABC, 32'h80000000, 5, 12'h003, {32'h0F003000, 32'hFFFFFFFF, 1'b0, 31'h7FFFFFFF}, 1'b1, {32'h1F003ABC, 32'h80000000}};
    vecs[11] = '{32'h0D002001, 32'd7, 5, 12'h002, {32'h0E002777, 32'd1, 1'b1, 31'd7}, 1'b1, {32'h0D002001, 32'd7}};

    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b1;
    init_sweep();
    mon_en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].ip, vecs[i].val, 1'b1, vecs[i]);
      idle(vecs[i].gap);
    end
    drain(40);

    for (int i = 0; i < 400; i++) begin
      light_out_alf = ($urandom_range(0, 9) < 3);
      if (!ip_addr_in_alf && $urandom_range(0, 3) != 0) begin
        logic [31:0] ip, v;
        ip = {8'hC0, 12'h200 + 12'($urandom_range(0, 3)), 12'($urandom_range(0, 3))};
        v  = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 6));
        send(ip, v, 1'b0, none);
      end else begin
        idle(1);
      end
    end
    light_out_alf = 1'b0;
    drain(200);
    chk("random_no_drops", 96'(drop_cnt), 96'd0);

    send(32'h55100001, 32'd100, 1'b0, none);
    idle(6);
    drain(20);
    chk("alf_low_before_burst", 96'(ip_addr_in_alf), 96'd0);
    light_out_alf = 1'b1;
    for (int i = 0; i < 20; i++) send(32'h66100002, 32'd1, 1'b0, none);
    repeat (4) void'(lq.pop_back());
    idle(8);
    chk("ovf_drop_cnt", 96'(drop_cnt), 96'd4);
    chk("ovf_alf_high", 96'(ip_addr_in_alf), 96'd1);
    chk("ovf_held_lights", 96'(lq.size()), 96'd16);
    light_out_alf = 1'b0;
    drain(60);
    idle(4);
    chk("alf_low_after_drain", 96'(ip_addr_in_alf), 96'd0);

    for (int i = 0; i < 3; i++) send(32'h77400000 + 32'(i), 32'd3, 1'b0, none);
    mon_en = 1'b0;
    reset = 1'b0;
    wq.delete();
    lq.delete();
    @(negedge clk);
    chk("midrst_drop_cnt", 96'(drop_cnt), 96'd0);
    chk("midrst_alf", 96'(ip_addr_in_alf), 96'd1);
    chk("midrst_wren", 96'(ram_wren), 96'd0);
    chk("midrst_light_wr", 96'(light_out_wr), 96'd0);
    reset = 1'b1;
    init_sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    failures++;
    $display("FAIL global_timeout actual=%0d cycles required=completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
